// File: rtl/intr_ctrl_n.sv
// Interrupt controller: N_IRQ edge-triggered lines plus one periodic timer channel.
// Fixed priority (lowest index wins), strict-priority nesting, hardware return stack.
module intr_ctrl_n #(
  parameter int unsigned     N_IRQ    = 4,
  parameter int unsigned     PC_W     = 10,
  parameter int unsigned     STACK_D  = 8,
  parameter int unsigned     TMR_W    = 16,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IRQ-1:0]             irq,
  input  logic [PC_W-1:0]              pc_next,
  input  logic                         ei,
  input  logic                         di,
  input  logic                         reti,
  input  logic                         mask_we,
  input  logic [N_IRQ:0]               mask_in,
  input  logic                         tmr_we,
  input  logic [TMR_W-1:0]             tmr_in,
  input  logic                         tmr_en,
  output logic                         take,
  output logic [PC_W-1:0]              vector,
  output logic [PC_W-1:0]              ret_addr,
  output logic [$clog2(N_IRQ+2)-1:0]   level,
  output logic                         err
);

  localparam int unsigned NCH = N_IRQ + 1;
  localparam int unsigned LW  = $clog2(N_IRQ + 2);
  localparam int unsigned AW  = $clog2(STACK_D);
  localparam int unsigned SPW = AW + 1;

  logic [N_IRQ-1:0] irq_q;
  logic [NCH-1:0]   pend_q, pend_d, mask_q, cand, win_oh;
  logic             gie_q, err_q;
  logic [LW-1:0]    level_q, level_d, win;
  logic             win_vld, prio_ok;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             stk_full, stk_empty;
  logic [AW-1:0]    top_idx, push_idx;
  logic [TMR_W-1:0] cnt_q, cnt_d, reload_q;
  logic             fire;

  logic [PC_W-1:0]  stk_pc_q  [STACK_D];
  logic [LW-1:0]    stk_lvl_q [STACK_D];

  assign cand   = pend_q & mask_q;
  assign win_oh = cand & ~(cand - NCH'(1));

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win     = LW'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign stk_full  = (sp_q == SPW'(STACK_D));
  assign stk_empty = (sp_q == '0);
  assign top_idx   = AW'(sp_q - SPW'(1));
  assign push_idx  = sp_q[AW-1:0];

  // Nesting only by strictly higher priority (smaller level number).
  assign prio_ok = (level_q == '0) || ((win + LW'(1)) < level_q);
  assign take    = gie_q & win_vld & prio_ok & ~stk_full & ~reti & ~reset;

  assign vector   = take ? (VEC_BASE + (PC_W'(win) << 1)) : '0;
  assign ret_addr = stk_empty ? '0 : stk_pc_q[top_idx];
  assign level    = level_q;
  assign err      = err_q;

  always_comb begin
    fire  = 1'b0;
    cnt_d = cnt_q;
    if (tmr_we) begin
      cnt_d = tmr_in;
    end else if (tmr_en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - TMR_W'(1);
      end else begin
        cnt_d = reload_q;
        fire  = 1'b1;
      end
    end
  end

  // A fresh event on the channel being taken survives the clear.
  always_comb begin
    pend_d = pend_q & ~(take ? win_oh : '0);
    pend_d = pend_d | {fire, irq & ~irq_q};
  end

  always_comb begin
    level_d = level_q;
    sp_d    = sp_q;
    if (take) begin
      level_d = win + LW'(1);
      sp_d    = sp_q + SPW'(1);
    end else if (reti && !stk_empty) begin
      level_d = stk_lvl_q[top_idx];
      sp_d    = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      gie_q    <= 1'b0;
      level_q  <= '0;
      sp_q     <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      err_q    <= 1'b0;
    end else begin
      irq_q   <= irq;
      pend_q  <= pend_d;
      level_q <= level_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      if (mask_we) mask_q <= mask_in;
      if (di) begin
        gie_q <= 1'b0;
      end else if (ei) begin
        gie_q <= 1'b1;
      end
      if (tmr_we) reload_q <= tmr_in;
      if (reti && stk_empty) err_q <= 1'b1;
    end
  end

  // Stack contents need no reset; validity is tracked by sp_q alone.
  always_ff @(posedge clk) begin
    if (take) begin
      stk_pc_q[push_idx]  <= pc_next;
      stk_lvl_q[push_idx] <= level_q;
    end
  end

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Bench for intr_ctrl_n: directed scenarios then random traffic, all checked
// against a queue-based reference model of the controller.
module tb_intr_ctrl_n;

  localparam int        N   = 4;
  localparam int        PCW = 10;
  localparam int        SD  = 2;
  localparam int        TW  = 16;
  localparam logic [9:0] VB = 10'h3F0;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   irq;
  logic [PCW-1:0] pc_next;
  logic           ei, di, reti, mask_we, tmr_we, tmr_en;
  logic [N:0]     mask_in;
  logic [TW-1:0]  tmr_in;
  logic           take, err;
  logic [PCW-1:0] vector, ret_addr;
  logic [2:0]     level;

  intr_ctrl_n #(
    .N_IRQ   (N),
    .PC_W    (PCW),
    .STACK_D (SD),
    .TMR_W   (TW),
    .VEC_BASE(VB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .pc_next (pc_next),
    .ei      (ei),
    .di      (di),
    .reti    (reti),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .tmr_we  (tmr_we),
    .tmr_in  (tmr_in),
    .tmr_en  (tmr_en),
    .take    (take),
    .vector  (vector),
    .ret_addr(ret_addr),
    .level   (level),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] pc;
    logic [2:0] lvl;
  } frame_t;

  frame_t     m_stk[$];
  logic [3:0] m_irq_q;
  logic [4:0] m_pend, m_mask;
  bit         m_gie, m_err;
  int         m_level, m_cnt, m_reload;
  bit         e_take;
  int         e_win;
  logic [9:0] e_vec, e_ret;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_comb();
    e_win = -1;
    for (int i = 0; i <= N; i++) if (m_pend[i] && m_mask[i] && e_win < 0) e_win = i;
    e_take = m_gie && (e_win >= 0) && (m_level == 0 || e_win + 1 < m_level) &&
             (m_stk.size() < SD) && !reti && !reset;
    e_vec = e_take ? 10'(int'(VB) + 2 * e_win) : 10'd0;
    e_ret = (m_stk.size() != 0) ? m_stk[$].pc : 10'd0;
  endtask

  task automatic model_seq();
    logic [4:0] np;
    frame_t     f;
    if (reset) begin
      m_irq_q = 0; m_pend = 0; m_mask = 0; m_gie = 0; m_level = 0;
      m_stk.delete(); m_cnt = 0; m_reload = 0; m_err = 0;
    end else begin
      np = m_pend;
      if (e_take) np[e_win] = 1'b0;
      for (int i = 0; i < N; i++) if (irq[i] && !m_irq_q[i]) np[i] = 1'b1;
      if (tmr_we) begin
        m_cnt = int'(tmr_in); m_reload = int'(tmr_in);
      end else if (tmr_en) begin
        if (m_cnt != 0) m_cnt--;
        else begin
          m_cnt = m_reload; np[N] = 1'b1;
        end
      end
      m_pend = np;
      m_irq_q = irq;
      if (mask_we) m_mask = mask_in;
      if (di) m_gie = 0;
      else if (ei) m_gie = 1;
      if (e_take) begin
        m_stk.push_back(frame_t'{pc: pc_next, lvl: 3'(m_level)});
        m_level = e_win + 1;
      end else if (reti) begin
        if (m_stk.size() != 0) begin
          f = m_stk.pop_back();
          m_level = int'(f.lvl);
        end else m_err = 1;
      end
    end
  endtask

  task automatic step();
    #2;
    model_comb();
    chk("take", take, e_take);
    chk("vector", vector, e_vec);
    chk("ret_addr", ret_addr, e_ret);
    chk("level", level, m_level);
    chk("err", err, m_err);
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic clr();
    ei = 0; di = 0; reti = 0; mask_we = 0; tmr_we = 0;
  endtask

  initial begin
    reset = 1; irq = 0; pc_next = 0; mask_in = 0; tmr_in = 0; tmr_en = 0;
    clr();
    step(); step();
    reset = 0;

    // basic take / return
    mask_we = 1; mask_in = 5'h1F; ei = 1; step(); clr();
    pc_next = 10'h040; irq = 4'b0100; step(); irq = 0;
    #1; chk("t1_take", take, 1); chk("t1_vec", vector, 10'h3F4);
    step();
    #1; chk("t1_level", level, 3);
    reti = 1; #1; chk("t1_ret", ret_addr, 10'h040);
    step(); reti = 0;
    #1; chk("t1_level0", level, 0);

    // priority and nesting
    pc_next = 10'h050; irq = 4'b1010; step(); irq = 0;
    #1; chk("t2_vec1", vector, 10'h3F2);
    step();
    pc_next = 10'h060; irq = 4'b0001; step(); irq = 0;
    #1; chk("t2_pre_take", take, 1); chk("t2_pre_vec", vector, 10'h3F0);
    step();
    #1; chk("t2_level1", level, 1); chk("t2_ret", ret_addr, 10'h060);
    step();
    reti = 1; step(); reti = 0;
    #1; chk("t2_ch3_held", take, 0);
    reti = 1; step(); reti = 0;
    #1; chk("t2_ch3_take", take, 1); chk("t2_ch3_vec", vector, 10'h3F6);
    step();
    reti = 1; step(); reti = 0;

    // masking
    mask_we = 1; mask_in = 5'h00; step(); clr();
    irq = 4'b0001; step(); irq = 0; step();
    #1; chk("t3_masked", take, 0);
    mask_we = 1; mask_in = 5'b00001; step(); clr();
    #1; chk("t3_unmask_take", take, 1); chk("t3_vec", vector, 10'h3F0);
    step();
    reti = 1; step(); reti = 0;

    // timer
    mask_we = 1; mask_in = 5'h10; tmr_we = 1; tmr_in = 16'd3; tmr_en = 1; step(); clr();
    for (int i = 0; i < 24; i++) begin
      reti = (m_level != 0);
      step();
    end
    tmr_en = 0; reti = (m_level != 0); step(); clr();

    // stack full and empty-stack reti
    reset = 1; step(); reset = 0;
    mask_we = 1; mask_in = 5'h0F; ei = 1; step(); clr();
    pc_next = 10'h100; irq = 4'b0100; step(); irq = 0; step();
    pc_next = 10'h110; irq = 4'b0010; step(); irq = 0; step();
    pc_next = 10'h120; irq = 4'b0001; step(); irq = 0;
    #1; chk("t5_full", take, 0);
    step(); step();
    reti = 1; step(); reti = 0;
    #1; chk("t5_after_pop", take, 1); chk("t5_vec", vector, 10'h3F0);
    step();
    reti = 1; step(); step(); step(); reti = 0;
    #1; chk("t5_err", err, 1);
    step(); step();
    #1; chk("t5_err_sticky", err, 1);

    // reset mid-ISR
    irq = 4'b0100; step(); irq = 0; step();
    irq = 4'b0010; step(); irq = 0; step();
    tmr_we = 1; tmr_in = 16'd5; tmr_en = 1; step(); clr();
    reset = 1; tmr_en = 0; step(); reset = 0;
    #1; chk("t6_level", level, 0); chk("t6_take", take, 0); chk("t6_ret", ret_addr, 0);
    chk("t6_err", err, 0);
    step(); step();

    // random traffic
    for (int c = 0; c < 800; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      irq     = 4'($urandom);
      pc_next = 10'($urandom);
      ei      = ($urandom_range(0, 3) == 0);
      di      = ($urandom_range(0, 15) == 0);
      reti    = ($urandom_range(0, 4) == 0);
      mask_we = ($urandom_range(0, 9) == 0);
      mask_in = 5'($urandom);
      tmr_we  = ($urandom_range(0, 19) == 0);
      tmr_in  = 16'($urandom_range(0, 6));
      tmr_en  = 1'($urandom);
      step();
    end
    reset = 0; clr();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
